// File: rtl/img_pkg.sv
// Shared definitions for the image windowing datapath: pixel width,
// default frame geometry, 3x3 window element indices and FSM states.
package img_pkg;

    localparam int PIX_W    = 8;
    localparam int ROWS_DEF = 242;
    localparam int COLS_DEF = 247;

    // Window element indices, row-major, top-left first.
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;
    localparam int WIN_N = 9;

    // FILL: rows 0-1 are being captured, no window can exist yet.
    // STREAM: rows 2..ROWS-1, interior windows are emitted.
    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } win_state_t;

endpackage

// File: rtl/prewitt_window_gen_if.sv
// Pixel-in / window-out bundle for prewitt_window_gen.
//
// Handshake: a transfer happens on every rising edge where in_valid is high;
// there is no ready, the consumer always accepts. in_sof is only meaningful
// when in_valid is high. On the output side win_valid qualifies win, out_row
// and out_col for exactly that cycle; frame_done is a standalone pulse.
interface prewitt_window_gen_if #(
    parameter int PIX_W = 8
);

    logic               in_valid;
    logic               in_sof;
    logic [PIX_W-1:0]   in_pixel;
    logic               win_valid;
    logic [9*PIX_W-1:0] win;
    logic [15:0]        out_row;
    logic [15:0]        out_col;
    logic               frame_done;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  win_valid, win, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output win_valid, win, out_row, out_col, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of storage. Read is combinational from the addressed word,
// so a read and a write to the same address in one cycle return the old
// value (read-before-write). Contents are not reset.
module line_buffer #(
    parameter int  DEPTH = 247,
    parameter int  WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Overwrite the addressed column with the newer row's pixel.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/prewitt_window_gen.sv
// Raster-to-3x3 window generator. Two line buffers hold the previous two
// rows; each accepted pixel pushes a column {row r-2, row r-1, current}
// into a 3x3 shift register. Only interior centres are emitted, one cycle
// after the pixel that completes them.
module prewitt_window_gen
    import img_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int PIX_W = img_pkg::PIX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    prewitt_window_gen_if.slave  bus,
    output win_state_t           fsm_state
);

    localparam int          AW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
    localparam logic [15:0] LAST_COL = 16'(COLS - 1);

    win_state_t         state;
    win_state_t         state_nxt;
    logic [15:0]        row;
    logic [15:0]        col;
    logic [15:0]        pos_row;
    logic [15:0]        pos_col;
    logic               last_col;
    logic               last_pix;
    logic               emit;
    logic [AW-1:0]      lb_addr;
    logic [PIX_W-1:0]   mid_pix;
    logic [PIX_W-1:0]   top_pix;
    logic [9*PIX_W-1:0] win_q;
    logic               win_valid_q;
    logic               frame_done_q;
    logic [15:0]        out_row_q;
    logic [15:0]        out_col_q;

    // Position of the pixel on the bus; in_sof overrides the counters.
    always_comb begin
        pos_row  = bus.in_sof ? 16'd0 : row;
        pos_col  = bus.in_sof ? 16'd0 : col;
        last_col = (pos_col == LAST_COL);
        last_pix = last_col && (pos_row == LAST_ROW);
        // Column gating keeps stale left columns from the previous row out.
        emit     = bus.in_valid && (state == STREAM) && !bus.in_sof &&
                   (pos_col >= 16'd2);
        lb_addr  = pos_col[AW-1:0];
    end

    // Next FSM state: enter STREAM at the end of row 1, leave at frame end
    // or when a new frame is started.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (bus.in_valid && !bus.in_sof && (pos_row == 16'd1) && last_col) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (bus.in_valid && (bus.in_sof || last_pix)) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (bus.in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= (pos_row == LAST_ROW) ? 16'd0 : pos_row + 16'd1;
            end else begin
                col <= pos_col + 16'd1;
                row <= pos_row;
            end
        end
    end

    // lb_mid holds row r-1, lb_top holds row r-2; the column cascades
    // mid -> top as the current pixel enters mid.
    line_buffer #(
        .DEPTH (COLS),
        .WIDTH (PIX_W)
    ) lb_mid (
        .clk   (clk),
        .wr_en (bus.in_valid),
        .addr  (lb_addr),
        .wdata (bus.in_pixel),
        .rdata (mid_pix)
    );

    line_buffer #(
        .DEPTH (COLS),
        .WIDTH (PIX_W)
    ) lb_top (
        .clk   (clk),
        .wr_en (bus.in_valid),
        .addr  (lb_addr),
        .wdata (mid_pix),
        .rdata (top_pix)
    );

    // 3x3 shift register: columns move left, the new column enters on the right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (bus.in_valid) begin
            win_q[W_TL*PIX_W +: PIX_W] <= win_q[W_TC*PIX_W +: PIX_W];
            win_q[W_TC*PIX_W +: PIX_W] <= win_q[W_TR*PIX_W +: PIX_W];
            win_q[W_TR*PIX_W +: PIX_W] <= top_pix;
            win_q[W_ML*PIX_W +: PIX_W] <= win_q[W_MC*PIX_W +: PIX_W];
            win_q[W_MC*PIX_W +: PIX_W] <= win_q[W_MR*PIX_W +: PIX_W];
            win_q[W_MR*PIX_W +: PIX_W] <= mid_pix;
            win_q[W_BL*PIX_W +: PIX_W] <= win_q[W_BC*PIX_W +: PIX_W];
            win_q[W_BC*PIX_W +: PIX_W] <= win_q[W_BR*PIX_W +: PIX_W];
            win_q[W_BR*PIX_W +: PIX_W] <= bus.in_pixel;
        end
    end

    // Output qualifiers and centre coordinates; coordinates hold between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            win_valid_q  <= emit;
            frame_done_q <= bus.in_valid && !bus.in_sof && last_pix;
            if (emit) begin
                out_row_q <= pos_row - 16'd1;
                out_col_q <= pos_col - 16'd1;
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.win        = win_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.frame_done = frame_done_q;
    assign fsm_state      = state;

endmodule
